// File: rtl/bf_exec_ctrl.sv
// bf_exec_ctrl: instruction-side sequencer for a Brainfuck-class core.
// Fetches opcodes over the IP line, issues one-cycle data/pointer strobes,
// holds I/O requests until acknowledged, and resolves brackets by scanning
// the IP forward or backward with a nesting-depth counter.
module bf_exec_ctrl #(
    parameter int OPCODE_W = 16,
    parameter int DEPTH_W  = 8
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                Run,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                IpReady,
    output logic                IpLoad,
    output logic                IpCount,
    output logic                IpReverse,
    input  logic                DataZero,
    input  logic                DataReady,
    output logic                ApInc,
    output logic                ApDec,
    output logic                DataInc,
    output logic                DataDec,
    output logic                IoOut,
    output logic                IoIn,
    input  logic                IoAck,
    output logic                Halted,
    output logic                Fault
);

    localparam logic [3:0] OP_INC    = 4'h1;
    localparam logic [3:0] OP_DEC    = 4'h2;
    localparam logic [3:0] OP_RIGHT  = 4'h3;
    localparam logic [3:0] OP_LEFT   = 4'h4;
    localparam logic [3:0] OP_OPEN   = 4'h5;
    localparam logic [3:0] OP_CLOSE  = 4'h6;
    localparam logic [3:0] OP_OUT    = 4'h7;
    localparam logic [3:0] OP_IN     = 4'h8;
    localparam logic [3:0] OP_HALT   = 4'hF;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_OP,
        S_DECODE,
        S_WAIT_DATA,
        S_WAIT_IO,
        S_ADVANCE,
        S_WAIT_STEP,
        S_SKIP_STEP,
        S_SKIP_WAIT_STEP,
        S_SKIP_LOAD,
        S_SKIP_WAIT_OP,
        S_HALTED
    } state_t;

    state_t               state, state_n;
    logic [3:0]           op, op_n;
    logic [DEPTH_W-1:0]   depth, depth_n;
    logic                 skip_back, skip_back_n;
    logic                 fault_q, fault_n;

    // Only the low nibble carries an instruction; the upper bits are free
    // for the program store to use and are deliberately ignored here.
    logic                 unused_opcode_hi;
    assign unused_opcode_hi = ^Opcode[OPCODE_W-1:4];

    // While scanning, the bracket that opens a new nesting level depends on
    // the scan direction; the other one closes a level.
    logic [3:0] nest_code, unnest_code;
    assign nest_code   = skip_back ? OP_CLOSE : OP_OPEN;
    assign unnest_code = skip_back ? OP_OPEN  : OP_CLOSE;

    assign Fault = fault_q;

    // State register plus the opcode, depth, direction and sticky fault.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= S_IDLE;
            op        <= '0;
            depth     <= '0;
            skip_back <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            // NOTE: registers take non-blocking assignments so every flop
            // samples the values from before this edge, independent of order.
            state     <= state_n;
            op        <= op_n;
            depth     <= depth_n;
            skip_back <= skip_back_n;
            fault_q   <= fault_n;
        end
    end

    // Next-state and Moore/Mealy output decode for the sequencer.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_n     = state;
        op_n        = op;
        depth_n     = depth;
        skip_back_n = skip_back;
        fault_n     = fault_q;
        IpLoad      = 1'b0;
        IpCount     = 1'b0;
        IpReverse   = 1'b0;
        ApInc       = 1'b0;
        ApDec       = 1'b0;
        DataInc     = 1'b0;
        DataDec     = 1'b0;
        IoOut       = 1'b0;
        IoIn        = 1'b0;
        Halted      = 1'b0;

        case (state)
            S_IDLE: begin
                if (Run) state_n = S_FETCH;
            end
            S_FETCH: begin
                IpLoad  = 1'b1;
                state_n = S_WAIT_OP;
            end
            S_WAIT_OP: begin
                if (IpReady) begin
                    op_n    = Opcode[3:0];
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_INC:   begin DataInc = 1'b1; state_n = S_WAIT_DATA; end
                    OP_DEC:   begin DataDec = 1'b1; state_n = S_WAIT_DATA; end
                    OP_RIGHT: begin ApInc   = 1'b1; state_n = S_WAIT_DATA; end
                    OP_LEFT:  begin ApDec   = 1'b1; state_n = S_WAIT_DATA; end
                    OP_OUT:   begin IoOut   = 1'b1; state_n = S_WAIT_IO;   end
                    OP_IN:    begin IoIn    = 1'b1; state_n = S_WAIT_IO;   end
                    OP_OPEN: begin
                        if (DataZero) begin
                            depth_n     = DEPTH_W'(1);
                            skip_back_n = 1'b0;
                            state_n     = S_SKIP_STEP;
                        end else begin
                            state_n = S_ADVANCE;
                        end
                    end
                    OP_CLOSE: begin
                        if (!DataZero) begin
                            depth_n     = DEPTH_W'(1);
                            skip_back_n = 1'b1;
                            state_n     = S_SKIP_STEP;
                        end else begin
                            state_n = S_ADVANCE;
                        end
                    end
                    OP_HALT:  state_n = S_HALTED;
                    default:  state_n = S_ADVANCE;
                endcase
            end
            S_WAIT_DATA: begin
                if (DataReady) state_n = S_ADVANCE;
            end
            S_WAIT_IO: begin
                IoOut = (op == OP_OUT);
                IoIn  = (op == OP_IN);
                if (IoAck) state_n = S_ADVANCE;
            end
            S_ADVANCE: begin
                IpCount = 1'b1;
                state_n = S_WAIT_STEP;
            end
            S_WAIT_STEP: begin
                if (IpReady) state_n = S_FETCH;
            end
            S_SKIP_STEP: begin
                IpCount   = 1'b1;
                IpReverse = skip_back;
                state_n   = S_SKIP_WAIT_STEP;
            end
            S_SKIP_WAIT_STEP: begin
                if (IpReady) state_n = S_SKIP_LOAD;
            end
            S_SKIP_LOAD: begin
                IpLoad  = 1'b1;
                state_n = S_SKIP_WAIT_OP;
            end
            S_SKIP_WAIT_OP: begin
                if (IpReady) begin
                    op_n    = Opcode[3:0];
                    state_n = S_SKIP_STEP;
                    if (Opcode[3:0] == nest_code) begin
                        if (depth == {DEPTH_W{1'b1}}) begin
                            fault_n = 1'b1;
                            state_n = S_HALTED;
                        end else begin
                            depth_n = depth + DEPTH_W'(1);
                        end
                    end else if (Opcode[3:0] == unnest_code) begin
                        depth_n = depth - DEPTH_W'(1);
                        // Matching bracket found: resume just after it.
                        if (depth == DEPTH_W'(1)) state_n = S_ADVANCE;
                    end
                end
            end
            S_HALTED: begin
                Halted = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule
